// File: rtl/mips_state_dumper.sv
// mips_state_dumper: watches a MIPS core run, detects halt (cycle budget or
// stalled PC), then streams the final PC and the register file over a
// valid/ready port. Registers are read through a spare asynchronous RF port.
module mips_state_dumper #(
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter int IDX_W        = 5,
  parameter int CYC_W        = 16,
  parameter int CYCLE_BUDGET = 4100,
  parameter int STALL_LIMIT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_in,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_is_pc,
  output logic [IDX_W-1:0]  dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic              halt_stall,
  output logic [CYC_W-1:0]  run_cycles
);

  localparam logic [CYC_W-1:0] BUDGET_C   = CYC_W'(CYCLE_BUDGET);
  localparam logic [CYC_W-1:0] STALL_C    = CYC_W'(STALL_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PC_OUT,
    S_REG_RD,
    S_REG_OUT,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CYC_W-1:0]   stall_cnt;
  logic [DATA_W-1:0]  pc_prev;
  logic               pc_same, stall_hit, budget_hit, halt, last_reg;

  // State register.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Halt detection, next-state selection and state-decoded status outputs.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave a latch behind.
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    pc_same    = (pc_in == pc_prev);
    stall_hit  = (STALL_LIMIT != 0) && pc_same && ((stall_cnt + CYC_W'(1)) == STALL_C);
    budget_hit = ((run_cycles + CYC_W'(1)) == BUDGET_C);
    halt       = stall_hit || budget_hit;
    last_reg   = (dump_index == LAST_IDX_C);
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (halt) state_nxt = S_PC_OUT;
      end
      S_PC_OUT: begin
        busy = 1'b1;
        if (dump_ready) state_nxt = S_REG_RD;
      end
      S_REG_RD: begin
        busy      = 1'b1;
        state_nxt = S_REG_OUT;
      end
      S_REG_OUT: begin
        busy = 1'b1;
        if (dump_ready) state_nxt = last_reg ? S_DONE : S_REG_RD;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Run counters, halt capture and the dump word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload registers are reset as well, because every output
      // must read zero straight out of reset, not only the control flops.
      run_cycles <= '0;
      stall_cnt  <= '0;
      pc_prev    <= '0;
      halt_stall <= 1'b0;
      rf_raddr   <= '0;
      dump_valid <= 1'b0;
      dump_is_pc <= 1'b0;
      dump_index <= '0;
      dump_data  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            run_cycles <= '0;
            stall_cnt  <= '0;
            pc_prev    <= pc_in;
            halt_stall <= 1'b0;
          end
        end
        S_RUN: begin
          run_cycles <= run_cycles + CYC_W'(1);
          stall_cnt  <= pc_same ? stall_cnt + CYC_W'(1) : '0;
          pc_prev    <= pc_in;
          if (halt) begin
            halt_stall <= stall_hit;
            dump_data  <= pc_in;
            dump_is_pc <= 1'b1;
            dump_index <= '0;
            dump_valid <= 1'b1;
          end
        end
        S_PC_OUT: begin
          if (dump_ready) begin
            rf_raddr   <= '0;
            dump_valid <= 1'b0;
          end
        end
        S_REG_RD: begin
          dump_data  <= rf_rdata;
          dump_index <= rf_raddr;
          dump_is_pc <= 1'b0;
          dump_valid <= 1'b1;
        end
        S_REG_OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (!last_reg) rf_raddr <= rf_raddr + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_state_dumper.sv
// Testbench for mips_state_dumper: drives PC traces and an RF model, predicts
// the halt cycle/cause from the PC trace and checks every dumped word.
module tb_mips_state_dumper;

  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int IDX_W = 5;
  localparam int CYC_W = 16;
  localparam int BUDGET = 20;
  localparam int STALL = 8;
  localparam int WW = 1 + IDX_W + DATA_W;
  localparam int NPC = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] pc_in = '0;
  logic [IDX_W-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic              dump_is_pc;
  logic [IDX_W-1:0]  dump_index;
  logic [DATA_W-1:0] dump_data;
  logic              busy, done, halt_stall;
  logic [CYC_W-1:0]  run_cycles;

  int pass_cnt = 0;
  int chk_cnt = 0;

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] pcs [NPC];
  logic [WW-1:0]     got [NUM_REGS+1];
  logic [WW-1:0]     first_got [NUM_REGS+1];

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];

  mips_state_dumper #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .CYC_W(CYC_W),
    .CYCLE_BUDGET(BUDGET), .STALL_LIMIT(STALL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_is_pc(dump_is_pc),
    .dump_index(dump_index), .dump_data(dump_data),
    .busy(busy), .done(done), .halt_stall(halt_stall), .run_cycles(run_cycles)
  );

  // Reference: walk the PC trace (pcs[0] is seen at the start edge, pcs[k] in
  // run cycle k) counting consecutive unchanged-PC cycles; halt at the first
  // cycle where that count reaches the stall limit or the budget is used up.
  task automatic model_halt(output int n, output bit by_stall);
    int eq;
    eq = 0;
    n = BUDGET;
    by_stall = 1'b0;
    for (int k = 1; k < NPC; k++) begin
      eq = (pcs[k] == pcs[k-1]) ? eq + 1 : 0;
      if ((STALL != 0 && eq >= STALL) || k >= BUDGET) begin
        n = k;
        by_stall = (STALL != 0 && eq >= STALL);
        break;
      end
    end
  endtask

  function automatic logic [WW-1:0] exp_word(input int i, input int n);
    logic [IDX_W-1:0] idx;
    if (i == 0) begin
      idx = '0;
      return {1'b1, idx, pcs[n]};
    end
    idx = IDX_W'(i - 1);
    return {1'b0, idx, rf[i-1]};
  endfunction

  task automatic fill_incr(input logic [DATA_W-1:0] base);
    for (int k = 0; k < NPC; k++) pcs[k] = base + DATA_W'(4 * k);
  endtask

  // One complete run + dump from IDLE or DONE, checked word by word.
  task automatic do_run(input string name, input bit rnd_ready, input bit rnd_start);
    int n_exp, cyc, nwords, last_acc;
    bit st_exp, seen_pc, hold;
    logic [WW-1:0] cur, hold_word, ew;
    model_halt(n_exp, st_exp);
    @(negedge clk);
    start = 1'b1;
    pc_in = pcs[0];
    dump_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1 || done !== 1'b0 || run_cycles !== '0) begin
      $display("FAIL %s_armed: busy=%b done=%b run_cycles=%0d, want busy=1 done=0 run_cycles=0",
               name, busy, done, run_cycles);
    end else pass_cnt++;
    cyc = 1; nwords = 0; last_acc = 0; seen_pc = 0; hold = 0;
    while (done !== 1'b1 && cyc < 400) begin
      pc_in = pcs[(cyc < NPC) ? cyc : NPC-1];
      dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd_start) start = ($urandom_range(0, 7) == 0);
      if (dump_valid === 1'b1) begin
        cur = {dump_is_pc, dump_index, dump_data};
        if (!seen_pc) begin
          seen_pc = 1;
          chk_cnt++;
          if (cyc != n_exp + 1 || halt_stall !== st_exp || run_cycles !== CYC_W'(n_exp)) begin
            $display("FAIL %s_halt: pc word at cycle %0d stall=%b run_cycles=%0d, want cycle %0d stall=%b run_cycles=%0d",
                     name, cyc, halt_stall, run_cycles, n_exp + 1, st_exp, n_exp);
          end else pass_cnt++;
        end
        if (hold) begin
          chk_cnt++;
          if (cur !== hold_word) begin
            $display("FAIL %s_stable: word changed while stalled: got %h want %h", name, cur, hold_word);
          end else pass_cnt++;
        end
        if (dump_ready) begin
          ew = (nwords <= NUM_REGS) ? exp_word(nwords, n_exp) : '0;
          chk_cnt++;
          if (nwords > NUM_REGS || cur !== ew) begin
            $display("FAIL %s_word%0d: got %h want %h", name, nwords, cur, ew);
          end else pass_cnt++;
          if (!rnd_ready && nwords > 0) begin
            chk_cnt++;
            if (cyc - last_acc != 2) begin
              $display("FAIL %s_rate%0d: spacing %0d cycles, want 2", name, nwords, cyc - last_acc);
            end else pass_cnt++;
          end
          if (nwords <= NUM_REGS) got[nwords] = cur;
          last_acc = cyc;
          nwords++;
          hold = 0;
        end else begin
          hold = 1;
          hold_word = cur;
        end
      end else if (hold) begin
        chk_cnt++;
        $display("FAIL %s_drop: valid dropped without transfer, got 0 want 1", name);
        hold = 0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    dump_ready = 1'b0;
    chk_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0 || nwords != NUM_REGS + 1) begin
      $display("FAIL %s_end: done=%b busy=%b valid=%b words=%0d, want done=1 busy=0 valid=0 words=%0d",
               name, done, busy, dump_valid, nwords, NUM_REGS + 1);
    end else pass_cnt++;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (halt_stall !== st_exp || run_cycles !== CYC_W'(n_exp) || done !== 1'b1) begin
      $display("FAIL %s_hold: stall=%b run_cycles=%0d done=%b, want stall=%b run_cycles=%0d done=1",
               name, halt_stall, run_cycles, done, st_exp, n_exp);
    end else pass_cnt++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({dump_valid, busy, done, halt_stall, dump_is_pc} !== 5'b0 || rf_raddr !== '0 ||
        dump_index !== '0 || dump_data !== '0 || run_cycles !== '0) begin
      $display("FAIL reset_state: valid=%b busy=%b done=%b stall=%b is_pc=%b raddr=%0d idx=%0d data=%h cyc=%0d, want all 0",
               dump_valid, busy, done, halt_stall, dump_is_pc, rf_raddr, dump_index, dump_data, run_cycles);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_dump;
    int cyc;
    fill_incr(32'h0000_1000);
    @(negedge clk);
    start = 1'b1;
    pc_in = pcs[0];
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!(dump_valid === 1'b1 && dump_is_pc === 1'b0 && dump_index == 3) && cyc < 200) begin
      pc_in = pcs[(cyc < NPC) ? cyc : NPC-1];
      dump_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk_cnt++;
    if (cyc >= 200) $display("FAIL rst_mid_reach: REG_OUT index 3 not reached in 200 cycles");
    else pass_cnt++;
    dump_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rf_raddr !== '0) begin
      $display("FAIL rst_mid_abort: valid=%b busy=%b done=%b raddr=%0d, want 0 0 0 0",
               dump_valid, busy, done, rf_raddr);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || run_cycles !== '0) begin
      $display("FAIL rst_mid_idle: valid=%b busy=%b done=%b run_cycles=%0d, want idle and 0",
               dump_valid, busy, done, run_cycles);
    end else pass_cnt++;
  endtask

  task automatic test_budget;
    fill_incr(32'h0040_0000);
    do_run("budget", 1'b0, 1'b0);
    chk_cnt++;
    if (run_cycles !== 16'd20 || halt_stall !== 1'b0 || got[0][DATA_W-1:0] !== 32'h0040_0050) begin
      $display("FAIL budget_result: run_cycles=%0d stall=%b pc=%h, want 20 0 00400050",
               run_cycles, halt_stall, got[0][DATA_W-1:0]);
    end else pass_cnt++;
  endtask

  task automatic test_stall;
    for (int k = 0; k < NPC; k++) pcs[k] = (k < 4) ? DATA_W'(4 * k) : 32'h0000_003C;
    do_run("stall", 1'b0, 1'b0);
    chk_cnt++;
    if (run_cycles !== 16'd12 || halt_stall !== 1'b1 || got[0][DATA_W-1:0] !== 32'h0000_003C) begin
      $display("FAIL stall_result: run_cycles=%0d stall=%b pc=%h, want 12 1 0000003c",
               run_cycles, halt_stall, got[0][DATA_W-1:0]);
    end else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    for (int k = 0; k < NPC; k++) pcs[k] = (k < 12) ? DATA_W'(4 * k) : 32'h0000_0100;
    do_run("simul", 1'b0, 1'b0);
    chk_cnt++;
    if (run_cycles !== 16'd20 || halt_stall !== 1'b1) begin
      $display("FAIL simul_result: run_cycles=%0d stall=%b, want 20 1", run_cycles, halt_stall);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int f;
    for (int it = 0; it < 4; it++) begin
      f = $urandom_range(1, 14);
      pcs[0] = $urandom & 32'hFFFF_FFFC;
      for (int k = 1; k < NPC; k++) begin
        if ((it[0] && k >= f) || $urandom_range(0, 3) == 0) pcs[k] = pcs[k-1];
        else pcs[k] = $urandom & 32'hFFFF_FFFC;
      end
      do_run($sformatf("bp%0d", it), 1'b1, 1'b1);
    end
  endtask

  task automatic test_rearm;
    fill_incr(32'h0000_2000);
    do_run("rearm_a", 1'b0, 1'b0);
    for (int i = 0; i <= NUM_REGS; i++) first_got[i] = got[i];
    for (int i = 0; i <= NUM_REGS; i++) got[i] = '0;
    do_run("rearm_b", 1'b0, 1'b0);
    for (int i = 0; i <= NUM_REGS; i++) begin
      chk_cnt++;
      if (got[i] !== first_got[i]) begin
        $display("FAIL rearm_same%0d: second dump %h, first dump %h", i, got[i], first_got[i]);
      end else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i * 32'h11);
    test_reset;
    test_reset_mid_dump;
    test_budget;
    test_stall;
    test_backpressure;
    test_simultaneous;
    test_rearm;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
